// File: rtl/rx_lane_arbiter.sv
// rx_lane_arbiter
//
// Merges the four PHY receive byte lanes into one valid/ready byte stream.
// Each lane has a one-byte holding register. A round-robin pointer picks the
// next full lane whenever the registered output slot is free. Lanes that
// deliver a byte into an occupied, non-granted holding register raise a
// sticky overflow flag. Idle symbols can optionally be discarded on capture.
//
// Ports:
//   clk_f              block clock, rising edge
//   reset              synchronous active-high reset
//   data_rx0..3        lane bytes
//   valid_rx0..3       per-lane one-cycle byte qualifiers
//   ready_out          downstream accepts data_arb this cycle
//   data_arb           merged output byte (registered)
//   valid_arb          data_arb/lane_arb valid (registered)
//   lane_arb           source lane of data_arb (registered)
//   overflow           sticky per-lane overflow flags, cleared only by reset
//   busy               any holding register full or output valid
module rx_lane_arbiter #(
    parameter int unsigned       DATA_W    = 8,
    parameter bit                DROP_IDLE = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_BYTE = 8'h7C
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_rx0,
    input  logic [DATA_W-1:0] data_rx1,
    input  logic [DATA_W-1:0] data_rx2,
    input  logic [DATA_W-1:0] data_rx3,
    input  logic              valid_rx0,
    input  logic              valid_rx1,
    input  logic              valid_rx2,
    input  logic              valid_rx3,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_arb,
    output logic              valid_arb,
    output logic [1:0]        lane_arb,
    output logic [3:0]        overflow,
    output logic              busy
);

    logic [DATA_W-1:0] lane_data [4];
    logic [3:0]        lane_valid;

    assign lane_data[0] = data_rx0;
    assign lane_data[1] = data_rx1;
    assign lane_data[2] = data_rx2;
    assign lane_data[3] = data_rx3;
    assign lane_valid   = {valid_rx3, valid_rx2, valid_rx1, valid_rx0};

    logic [DATA_W-1:0] hold_data_q [4];
    logic [DATA_W-1:0] hold_data_d [4];
    logic [3:0]        hold_full_q, hold_full_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        ovf_q, ovf_d;

    logic              slot_free;
    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [3:0]        cand;

    assign slot_free = !valid_q || ready_out;

    // Candidate bytes: valid and, when idle dropping is enabled, not idle.
    always_comb begin
        cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = lane_valid[i] && (!DROP_IDLE || (lane_data[i] != IDLE_BYTE));
        end
    end

    // First full lane at or after ptr, wrapping modulo 4.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        if (slot_free) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!grant_vld && hold_full_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    always_comb begin
        hold_full_d = hold_full_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        ovf_d       = ovf_q;
        for (int i = 0; i < 4; i++) begin
            hold_data_d[i] = hold_data_q[i];
        end

        if (grant_vld) begin
            data_d                 = hold_data_q[grant_idx];
            lane_d                 = grant_idx;
            valid_d                = 1'b1;
            hold_full_d[grant_idx] = 1'b0;
            ptr_d                  = grant_idx + 2'd1;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end

        // A lane being granted this edge can accept a refill in the same edge.
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                if (!hold_full_q[i] || (grant_vld && (grant_idx == 2'(i)))) begin
                    hold_data_d[i] = lane_data[i];
                    hold_full_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            hold_full_q <= '0;
            ptr_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            lane_q      <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                hold_data_q[i] <= '0;
            end
        end else begin
            hold_full_q <= hold_full_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                hold_data_q[i] <= hold_data_d[i];
            end
        end
    end

    assign data_arb  = data_q;
    assign valid_arb = valid_q;
    assign lane_arb  = lane_q;
    assign overflow  = ovf_q;
    assign busy      = (|hold_full_q) | valid_q;

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// Testbench for rx_lane_arbiter: directed scenarios followed by a randomized
// phase, all outputs compared every cycle against a behavioural model.
module tb_rx_lane_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [4];
    logic       vin [4];
    logic       rdy;
    logic [7:0] data_arb;
    logic       valid_arb;
    logic [1:0] lane_arb;
    logic [3:0] overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic       m_full [4];
    logic [7:0] m_data [4];
    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_dout;
    int         m_lane;
    logic [3:0] m_ovf;

    always #5 clk = ~clk;

    rx_lane_arbiter dut (
        .clk_f     (clk),
        .reset     (rst),
        .data_rx0  (din[0]),
        .data_rx1  (din[1]),
        .data_rx2  (din[2]),
        .data_rx3  (din[3]),
        .valid_rx0 (vin[0]),
        .valid_rx1 (vin[1]),
        .valid_rx2 (vin[2]),
        .valid_rx3 (vin[3]),
        .ready_out (rdy),
        .data_arb  (data_arb),
        .valid_arb (valid_arb),
        .lane_arb  (lane_arb),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge of the spec's rules to the model.
    task automatic model_edge(input logic [3:0] v, input logic [31:0] d, input logic r,
                              input logic rs);
        logic nfull [4];
        int   g;
        logic free;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 1'b0;
                m_data[i] = 8'h00;
            end
            m_ptr = 0; m_valid = 1'b0; m_dout = 8'h00; m_lane = 0; m_ovf = 4'b0000;
            return;
        end
        free = !m_valid || r;
        g = -1;
        for (int i = 0; i < 4; i++) nfull[i] = m_full[i];
        if (free) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_full[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        if (g >= 0) begin
            m_dout   = m_data[g];
            m_lane   = g;
            m_valid  = 1'b1;
            nfull[g] = 1'b0;
            m_ptr    = (g + 1) % 4;
        end else if (free) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] && d[8*i +: 8] != 8'h7C) begin
                if (!m_full[i] || g == i) begin
                    m_data[i] = d[8*i +: 8];
                    nfull[i]  = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) m_full[i] = nfull[i];
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = m_valid;
        for (int i = 0; i < 4; i++) exp_busy = exp_busy | m_full[i];
        chk("valid_arb", {31'd0, valid_arb}, {31'd0, m_valid});
        if (m_valid) begin
            chk("data_arb", {24'd0, data_arb}, {24'd0, m_dout});
            chk("lane_arb", {30'd0, lane_arb}, m_lane);
        end
        chk("overflow", {28'd0, overflow}, {28'd0, m_ovf});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, check 1ns later.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r,
                        input logic rs);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vin[i] = v[i];
            din[i] = d[8*i +: 8];
        end
        rdy = r;
        rst = rs;
        @(posedge clk);
        model_edge(v, d, r, rs);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            vin[i] = 1'b0;
        end
        rdy = 1'b0;
        rst = 1'b1;
        model_edge(4'h0, 32'h0, 1'b0, 1'b1);

        // Reset with random lane activity.
        step(4'($urandom), $urandom, 1'($urandom), 1'b1);
        step(4'($urandom), $urandom, 1'($urandom), 1'b1);
        chk("rst_data", {24'd0, data_arb}, 32'h0);
        chk("rst_valid", {31'd0, valid_arb}, 32'h0);
        chk("rst_lane", {30'd0, lane_arb}, 32'h0);
        chk("rst_ovf", {28'd0, overflow}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("idle_valid", {31'd0, valid_arb}, 32'h0);

        // Single-lane latency.
        step(4'b0100, 32'h00A50000, 1'b1, 1'b0);
        chk("lat_k_valid", {31'd0, valid_arb}, 32'h0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("lat_k1_valid", {31'd0, valid_arb}, 32'h1);
        chk("lat_k1_data", {24'd0, data_arb}, 32'hA5);
        chk("lat_k1_lane", {30'd0, lane_arb}, 32'h2);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("lat_k2_valid", {31'd0, valid_arb}, 32'h0);

        // Round-robin from ptr=0.
        step(4'h0, 32'h0, 1'b1, 1'b1);
        for (int b = 0; b < 2; b++) begin
            step(4'hF, 32'h13121110, 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) begin
                step(4'h0, 32'h0, 1'b1, 1'b0);
                chk("rr_lane", {30'd0, lane_arb}, j);
                chk("rr_data", {24'd0, data_arb}, 32'h10 + j);
            end
        end
        step(4'b1010, 32'h23002100, 1'b1, 1'b0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("rr13_first", {30'd0, lane_arb}, 32'h1);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("rr13_second", {30'd0, lane_arb}, 32'h3);
        step(4'h0, 32'h0, 1'b1, 1'b0);

        // Stall and overflow on lane 0.
        step(4'b0001, 32'h01, 1'b0, 1'b0);
        step(4'b0001, 32'h02, 1'b0, 1'b0);
        step(4'b0001, 32'h03, 1'b0, 1'b0);
        chk("stall_data", {24'd0, data_arb}, 32'h01);
        chk("stall_ovf0", {31'd0, overflow[0]}, 32'h1);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("stall_next", {24'd0, data_arb}, 32'h02);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("ovf_sticky", {31'd0, overflow[0]}, 32'h1);

        // Same-edge refill on lane 1.
        step(4'b0010, 32'h0000AA00, 1'b1, 1'b0);
        step(4'b0010, 32'h00005500, 1'b1, 1'b0);
        chk("refill_ovf1", {31'd0, overflow[1]}, 32'h0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("refill_data", {24'd0, data_arb}, 32'h55);
        step(4'h0, 32'h0, 1'b1, 1'b0);

        // Idle drop on lane 3.
        step(4'b1000, 32'h7C000000, 1'b1, 1'b0);
        chk("idle_busy", {31'd0, busy}, 32'h0);
        step(4'b1000, 32'h3C000000, 1'b1, 1'b0);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        chk("idle_pass", {24'd0, data_arb}, 32'h3C);
        step(4'h0, 32'h0, 1'b1, 1'b0);
        step(4'b1000, 32'h11000000, 1'b0, 1'b0);
        step(4'b1000, 32'h22000000, 1'b0, 1'b0);
        step(4'b1000, 32'h7C000000, 1'b0, 1'b0);
        chk("idle_no_ovf3", {31'd0, overflow[3]}, 32'h0);

        // Reset mid-operation discards everything.
        step(4'hF, $urandom, 1'b0, 1'b1);
        chk("midrst_valid", {31'd0, valid_arb}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        chk("midrst_ovf", {28'd0, overflow}, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rv = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                rd[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h7C : 8'($urandom);
            end
            step(rv, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_lane_arbiter.md
Name: rx_lane_arbiter

Overview:
- Round-robin scheduler that merges the four parallel byte lanes produced by the PHY receive path (data_rx0..3 / valid_rx0..3) into one byte stream with a valid/ready handshake toward the downstream consumer.
- Sits directly after phy_rx in the clk_f domain.
- Each lane has a one-byte holding register. Lanes that produce a byte while their holding register is still occupied are flagged as overflowed.
- Optionally discards idle bytes so that only payload reaches the consumer.

Parameters:
- DATA_W, 8, width of each lane byte and of the merged output.
- DROP_IDLE, 1, 1 = discard incoming bytes equal to IDLE_BYTE; 0 = pass them like any other byte.
- IDLE_BYTE, 8'h7C, idle symbol value compared when DROP_IDLE=1.

Ports:
- clk_f  input  1  block clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_rx0  input  DATA_W  lane 0 byte.
- data_rx1  input  DATA_W  lane 1 byte.
- data_rx2  input  DATA_W  lane 2 byte.
- data_rx3  input  DATA_W  lane 3 byte.
- valid_rx0  input  1  lane 0 byte valid, one-cycle qualifier.
- valid_rx1  input  1  lane 1 byte valid.
- valid_rx2  input  1  lane 2 byte valid.
- valid_rx3  input  1  lane 3 byte valid.
- ready_out  input  1  downstream accepts data_arb this cycle.
- data_arb  output  DATA_W  merged output byte, registered.
- valid_arb  output  1  data_arb/lane_arb valid, registered.
- lane_arb  output  2  source lane index of data_arb, registered.
- overflow  output  4  sticky per-lane overflow flags; bit i corresponds to lane i.
- busy  output  1  high when any holding register is full or valid_arb=1.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk_f rising edge.
  - Outputs after reset: data_arb=0, valid_arb=0, lane_arb=0, overflow=4'b0000, busy=0.
  - Internal state after reset: all hold_full=0, round-robin pointer ptr=0.
  - Reset asserted mid-operation discards held bytes and any pending output byte.
- Capture, lane i, per edge:
  - If valid_rx_i=1 and (DROP_IDLE=0 or data_rx_i!=IDLE_BYTE), the byte is a candidate.
  - A candidate is written to hold_data[i] and sets hold_full[i]=1 when hold_full[i]=0, or when lane i is granted on this same edge.
  - Otherwise the candidate is dropped, hold_data[i] is unchanged and overflow[i]<=1.
  - overflow bits clear only on reset.
  - Dropped idle bytes never set overflow.
- Output slot is free on an edge when valid_arb=0 or ready_out=1.
- Grant, evaluated only when the slot is free:
  - Search hold_full starting at lane ptr, ascending modulo 4; the first full lane g is granted.
  - On grant: data_arb<=hold_data[g], lane_arb<=g, valid_arb<=1, hold_full[g]<=0 (unless refilled on the same edge), ptr<=(g+1) mod 4.
  - If the slot is free and no lane is full: valid_arb<=0; data_arb, lane_arb and ptr hold.
- Stall: when valid_arb=1 and ready_out=0, data_arb, lane_arb, valid_arb and ptr hold. Holding registers keep filling only where empty.
- Latency: a byte presented with valid_rx_i at edge k appears on data_arb after edge k+1, given no contention and a free slot. That is 2 edges, or 1 cycle of registered latency after capture.
- Throughput: 1 byte/cycle on the output with ready_out held at 1.
  - Four lanes all valid every cycle therefore overflow. This is legal and is flagged.
  - Each lane gets at most 1 grant per 4 grants while all lanes are full.
- Fairness: the lane that wins a grant has the lowest priority on the next grant.
- busy is combinational: (|hold_full) | valid_arb.

Test Plan:
- Reset/idle: assert reset 2 cycles with random lane inputs -> all outputs 0, ptr=0. Deassert with no valid -> valid_arb stays 0, busy=0.
- Single lane latency: valid_rx2=1, data_rx2=8'hA5 at edge k, ready_out=1 -> after edge k+1: valid_arb=1, data_arb=8'hA5, lane_arb=2; after edge k+2: valid_arb=0.
- Round-robin: all four lanes valid for one cycle with bytes 8'h10..8'h13, ready_out=1 -> output order lanes 0,1,2,3 on consecutive cycles. Next burst with ptr=0 repeats 0,1,2,3; with lanes 1 and 3 only, the order is 1,3.
- Stall/overflow: ready_out=0; lane 0 sends 8'h01 then 8'h02 then 8'h03 -> data_arb=8'h01 held; hold has 8'h02; 8'h03 dropped and overflow[0]=1. Raise ready_out -> 8'h01 then 8'h02 are delivered, overflow stays 1 until reset.
- Same-edge refill: lane 1 full and granted on the edge it receives 8'h55 -> no overflow, 8'h55 delivered on a later grant.
- Idle drop: DROP_IDLE=1, lane 3 sends 8'h7C, then 8'h3C -> only 8'h3C is output. With a full holding register, the 8'h7C does not set overflow[3].
